mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATABITS, default 32, memory word width.
REQ-002 SHALL have parameter ADDRBITS, default 32, byte address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports pN_addr (N=0,1)  input  ADDRBITS  requester byte address.
REQ-006 SHALL have ports pN_in  input  DATABITS  requester write data.
REQ-007 SHALL have ports pN_out  output  DATABITS  read data returned to requester N.
REQ-008 SHALL have ports pN_out_valid  output  1  pN_out holds a valid read word this cycle.
REQ-009 SHALL have ports pN_rdreq  input  1  one-cycle read-burst request pulse.
REQ-010 SHALL have ports pN_wrreq  input  1  one-cycle single-word write request pulse.
REQ-011 SHALL have ports pN_burstlen  input  16  read burst length in words.
REQ-012 SHALL have ports pN_ready  output  1  port N can accept a new request.
REQ-013 SHALL have port mem_addr  output  ADDRBITS  address to memory.
REQ-014 SHALL have port mem_in  output  DATABITS  write data to memory.
REQ-015 SHALL have port mem_out  input  DATABITS  read data from memory.
REQ-016 SHALL have port mem_out_valid  input  1  memory read word valid.
REQ-017 SHALL have port mem_rdreq  output  1  one-cycle read command pulse.
REQ-018 SHALL have port mem_wrreq  output  1  one-cycle write command pulse.
REQ-019 SHALL have port mem_burstlen  output  16  burst length of current read.

Function
REQ-020 SHALL capture pN_addr, pN_in, pN_burstlen and request type into port N's pending slot on the edge sampling pN_rdreq or pN_wrreq while pN_ready=1; a request while pN_ready=0 SHALL be ignored.
REQ-021 SHALL drive pN_ready=0 from the edge capturing a request until the cycle after its completion; one outstanding request per port.
REQ-022 SHALL treat simultaneous pN_rdreq and pN_wrreq as a read; the write is dropped.
REQ-023 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE; IDLE->RD_ISSUE or WR_ISSUE on grant, RD_ISSUE->RD_WAIT, RD_WAIT->IDLE on last word, WR_ISSUE->IDLE.
REQ-024 SHALL, in IDLE, grant from pending slots and requests arriving that edge; a request in cycle t while IDLE SHALL give mem_rdreq/mem_wrreq=1 in cycle t+1.
REQ-025 SHALL arbitrate round-robin: with both ports pending, grant the port not granted last; a single pending port is granted immediately.
REQ-026 SHALL assert mem_rdreq (RD_ISSUE) or mem_wrreq (WR_ISSUE) for exactly one cycle, with mem_addr/mem_in/mem_burstlen from the granted slot, held stable through RD_WAIT.
REQ-027 SHALL route mem_out to pN_out and assert pN_out_valid=mem_out_valid combinationally only for the owner in RD_ISSUE/RD_WAIT; the other port's out_valid=0 and out=0.
REQ-028 SHALL count read words in a 16-bit counter; the word with count==burstlen-1 ends the burst; burstlen 0 SHALL be treated as 1.
REQ-029 SHALL ignore mem_out_valid in IDLE and WR_ISSUE.
REQ-030 SHALL complete a write in WR_ISSUE with no memory acknowledge; next grant possible the following edge.

Reset
REQ-031 SHALL, on reset_n=0, immediately enter IDLE, clear pending slots and counter, set last-grant to port 1 (port 0 wins first tie), drive all mem_* and pN_out/pN_out_valid to 0 and pN_ready to 1.
REQ-032 SHALL abandon any in-flight burst on reset mid-operation; no completion is reported.

Structure
REQ-033 SHALL place state encoding, port index constants and the 16-bit burst width in shared package mem_arb_pkg.
REQ-034 SHALL instantiate sub-module mem_arb_slot twice (pending request capture and ready generation per port).

Verification
REQ-035 p0 read addr 0x80 burstlen 1, memory valid one cycle after mem_rdreq -> mem_rdreq next cycle with mem_addr=0x80, one p0_out_valid with word 0x20 of ROM, p0_ready high again.
REQ-036 p0 and p1 read same cycle after reset -> p0 granted first, p1 granted the edge after p0 completes; outputs never cross ports.
REQ-037 p1 read burstlen 4 -> four p1_out_valid pulses, state IDLE after fourth; p0 request mid-burst waits, p0_ready=0.
REQ-038 p1 write addr 0x88 data 0xDEADBEEF -> single mem_wrreq cycle, mem_in=0xDEADBEEF, no out_valid, p1_ready returns.
REQ-039 burstlen 0 read; second p0_rdreq while p0_ready=0 -> one word returned, second request ignored.
REQ-040 reset_n pulsed low during RD_WAIT -> outputs zero immediately, IDLE, late mem_out_valid produces no pN_out_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// port index constants, burst counter width and burst end helper.
package mem_arb_pkg;

    localparam int unsigned BURST_W = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WR_ISSUE = 2'd3
    } arb_state_t;

    // Index of the final word of a burst; a zero length means one word.
    function automatic logic [BURST_W-1:0] last_index(input logic [BURST_W-1:0] len);
        return (len == '0) ? '0 : len - BURST_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// Per-port request slot: captures one request, holds it until granted,
// and keeps the port busy until the arbiter reports completion.
//   i_addr/i_wdata/i_burstlen/i_rdreq/i_wrreq : requester side
//   i_grant   : arbiter takes this request (may be the same edge it arrives)
//   i_done    : arbiter finished this port's request
//   o_req_c   : a request is available (held or arriving this cycle)
//   o_*_c     : fields of that request (held copy or live inputs)
//   o_ready   : port can accept a new request
module mem_arb_slot
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATABITS = 32,
    parameter int unsigned ADDRBITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] i_addr,
    input  logic [DATABITS-1:0] i_wdata,
    input  logic [BURST_W-1:0]  i_burstlen,
    input  logic                i_rdreq,
    input  logic                i_wrreq,
    input  logic                i_grant,
    input  logic                i_done,
    output logic                o_req_c,
    output logic                o_is_read_c,
    output logic [ADDRBITS-1:0] o_addr_c,
    output logic [DATABITS-1:0] o_wdata_c,
    output logic [BURST_W-1:0]  o_burstlen_c,
    output logic                o_ready
);

    logic                r_ready;
    logic                r_pending;
    logic                r_is_read;
    logic [ADDRBITS-1:0] r_addr;
    logic [DATABITS-1:0] r_wdata;
    logic [BURST_W-1:0]  r_burstlen;
    logic                w_accept;

    assign w_accept = r_ready & (i_rdreq | i_wrreq);

    // Capture on accept; a same-edge grant means nothing stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready    <= 1'b1;
            r_pending  <= 1'b0;
            r_is_read  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_burstlen <= '0;
        end else if (w_accept) begin
            r_ready    <= 1'b0;
            r_pending  <= ~i_grant;
            r_is_read  <= i_rdreq;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_burstlen <= i_burstlen;
        end else begin
            if (i_grant) r_pending <= 1'b0;
            if (i_done)  r_ready   <= 1'b1;
        end
    end

    // Read wins when both strobes arrive together.
    assign o_req_c      = r_pending | w_accept;
    assign o_is_read_c  = r_pending ? r_is_read  : i_rdreq;
    assign o_addr_c     = r_pending ? r_addr     : i_addr;
    assign o_wdata_c    = r_pending ? r_wdata    : i_wdata;
    assign o_burstlen_c = r_pending ? r_burstlen : i_burstlen;
    assign o_ready      = r_ready;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: one outstanding request per port,
// read bursts or single-word writes, read data routed to the owning port.
//   clk, reset_n                 : clock, async active-low reset
//   pN_addr/pN_in/pN_burstlen    : request fields for port N
//   pN_rdreq/pN_wrreq            : one-cycle request strobes
//   pN_out/pN_out_valid          : read data returned to port N
//   pN_ready                     : port N can take a new request
//   mem_addr/mem_in/mem_burstlen : command fields to memory
//   mem_rdreq/mem_wrreq          : one-cycle command strobes
//   mem_out/mem_out_valid        : read data from memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATABITS = 32,
    parameter int unsigned ADDRBITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] p0_addr,
    input  logic [DATABITS-1:0] p0_in,
    output logic [DATABITS-1:0] p0_out,
    output logic                p0_out_valid,
    input  logic                p0_rdreq,
    input  logic                p0_wrreq,
    input  logic [BURST_W-1:0]  p0_burstlen,
    output logic                p0_ready,
    input  logic [ADDRBITS-1:0] p1_addr,
    input  logic [DATABITS-1:0] p1_in,
    output logic [DATABITS-1:0] p1_out,
    output logic                p1_out_valid,
    input  logic                p1_rdreq,
    input  logic                p1_wrreq,
    input  logic [BURST_W-1:0]  p1_burstlen,
    output logic                p1_ready,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_in,
    input  logic [DATABITS-1:0] mem_out,
    input  logic                mem_out_valid,
    output logic                mem_rdreq,
    output logic                mem_wrreq,
    output logic [BURST_W-1:0]  mem_burstlen
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                r_last;
    logic                r_owner;
    logic [ADDRBITS-1:0] r_addr;
    logic [DATABITS-1:0] r_wdata;
    logic [BURST_W-1:0]  r_len;
    logic [BURST_W-1:0]  r_cnt;

    logic                w_req0, w_req1, w_isrd0, w_isrd1;
    logic [ADDRBITS-1:0] w_addr0, w_addr1;
    logic [DATABITS-1:0] w_wd0, w_wd1;
    logic [BURST_W-1:0]  w_len0, w_len1;
    logic                w_grant_any, w_grant_sel, w_done_any;
    logic                w_grant0, w_grant1, w_done0, w_done1;
    logic                w_last_word, w_rd_active;

    mem_arb_slot #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS)) u_slot0 (
        .clk(clk), .reset_n(reset_n),
        .i_addr(p0_addr), .i_wdata(p0_in), .i_burstlen(p0_burstlen),
        .i_rdreq(p0_rdreq), .i_wrreq(p0_wrreq),
        .i_grant(w_grant0), .i_done(w_done0),
        .o_req_c(w_req0), .o_is_read_c(w_isrd0), .o_addr_c(w_addr0),
        .o_wdata_c(w_wd0), .o_burstlen_c(w_len0), .o_ready(p0_ready)
    );

    mem_arb_slot #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS)) u_slot1 (
        .clk(clk), .reset_n(reset_n),
        .i_addr(p1_addr), .i_wdata(p1_in), .i_burstlen(p1_burstlen),
        .i_rdreq(p1_rdreq), .i_wrreq(p1_wrreq),
        .i_grant(w_grant1), .i_done(w_done1),
        .o_req_c(w_req1), .o_is_read_c(w_isrd1), .o_addr_c(w_addr1),
        .o_wdata_c(w_wd1), .o_burstlen_c(w_len1), .o_ready(p1_ready)
    );

    assign w_last_word = (r_cnt == last_index(r_len));
    assign w_rd_active = (r_state == ST_RD_ISSUE) || (r_state == ST_RD_WAIT);

    // Next state, grant choice and completion.
    always_comb begin
        w_next_state = r_state;
        w_grant_any  = 1'b0;
        w_grant_sel  = PORT0;
        w_done_any   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant_any  = 1'b1;
                    // On a tie, the port not granted last time wins.
                    w_grant_sel  = (w_req0 && w_req1) ? ~r_last : w_req1;
                    w_next_state = (w_grant_sel ? w_isrd1 : w_isrd0) ? ST_RD_ISSUE : ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE, ST_RD_WAIT: begin
                if (mem_out_valid && w_last_word) begin
                    w_done_any   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_state == ST_RD_ISSUE) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_WR_ISSUE: begin
                w_done_any   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_grant0 = w_grant_any & (w_grant_sel == PORT0);
    assign w_grant1 = w_grant_any & (w_grant_sel == PORT1);
    assign w_done0  = w_done_any  & (r_owner == PORT0);
    assign w_done1  = w_done_any  & (r_owner == PORT1);

    // State, granted command fields and burst word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= PORT1;
            r_owner <= PORT0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_any) begin
                r_last  <= w_grant_sel;
                r_owner <= w_grant_sel;
                r_addr  <= w_grant_sel ? w_addr1 : w_addr0;
                r_wdata <= w_grant_sel ? w_wd1   : w_wd0;
                r_len   <= w_grant_sel ? w_len1  : w_len0;
                r_cnt   <= '0;
            end else if (w_rd_active && mem_out_valid) begin
                r_cnt <= r_cnt + BURST_W'(1);
            end
        end
    end

    assign mem_rdreq    = (r_state == ST_RD_ISSUE);
    assign mem_wrreq    = (r_state == ST_WR_ISSUE);
    assign mem_addr     = r_addr;
    assign mem_in       = r_wdata;
    assign mem_burstlen = r_len;

    // Read data reaches only the owner, and only while a read is in flight.
    assign p0_out_valid = w_rd_active && (r_owner == PORT0) && mem_out_valid;
    assign p1_out_valid = w_rd_active && (r_owner == PORT1) && mem_out_valid;
    assign p0_out       = (w_rd_active && (r_owner == PORT0)) ? mem_out : '0;
    assign p1_out       = (w_rd_active && (r_owner == PORT1)) ? mem_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] p0_addr, p0_in, p0_out, p1_addr, p1_in, p1_out;
    logic        p0_out_valid, p0_rdreq, p0_wrreq, p0_ready;
    logic        p1_out_valid, p1_rdreq, p1_wrreq, p1_ready;
    logic [15:0] p0_burstlen, p1_burstlen, mem_burstlen;
    logic [31:0] mem_addr, mem_in;
    logic [31:0] mem_out = '0;
    logic        mem_out_valid = 1'b0;
    logic        mem_rdreq, mem_wrreq;

    int total = 0;
    int bad   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    logic [31:0] m_ptr = '0;
    logic [15:0] m_rem = '0;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_addr(p0_addr), .p0_in(p0_in), .p0_out(p0_out), .p0_out_valid(p0_out_valid),
        .p0_rdreq(p0_rdreq), .p0_wrreq(p0_wrreq), .p0_burstlen(p0_burstlen), .p0_ready(p0_ready),
        .p1_addr(p1_addr), .p1_in(p1_in), .p1_out(p1_out), .p1_out_valid(p1_out_valid),
        .p1_rdreq(p1_rdreq), .p1_wrreq(p1_wrreq), .p1_burstlen(p1_burstlen), .p1_ready(p1_ready),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
        .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_burstlen(mem_burstlen)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] idx);
        return {16'hC0DE, idx[15:0]};
    endfunction

    // Memory model: first word the cycle after mem_rdreq, then one per cycle.
    // It ignores reset_n so a burst in flight keeps streaming after a DUT reset.
    always @(posedge clk) begin
        if (mem_rdreq) begin
            mem_out_valid <= 1'b1;
            mem_out       <= rom(mem_addr >> 2);
            m_ptr         <= (mem_addr >> 2) + 32'd1;
            m_rem         <= (mem_burstlen == 16'd0) ? 16'd0 : mem_burstlen - 16'd1;
        end else if (m_rem != 16'd0) begin
            mem_out_valid <= 1'b1;
            mem_out       <= rom(m_ptr);
            m_ptr         <= m_ptr + 32'd1;
            m_rem         <= m_rem - 16'd1;
        end else begin
            mem_out_valid <= 1'b0;
            mem_out       <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every returned word must be the next one expected for that port.
    always @(negedge clk) begin
        check("no_cross", 64'(p0_out_valid & p1_out_valid), 64'd0);
        if (p0_out_valid === 1'b1) begin
            check("p0_word_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) check("p0_out", 64'(p0_out), 64'(q0.pop_front()));
        end
        if (p1_out_valid === 1'b1) begin
            check("p1_word_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) check("p1_out", 64'(p1_out), 64'(q1.pop_front()));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [15:0] len, input bit push);
        int n;
        n = (len == 16'd0) ? 1 : int'(len);
        if (port == 1'b0) begin
            p0_rdreq = rd; p0_wrreq = wr; p0_addr = addr; p0_in = data; p0_burstlen = len;
            if (push && rd) for (int i = 0; i < n; i++) q0.push_back(rom((addr >> 2) + 32'(i)));
        end else begin
            p1_rdreq = rd; p1_wrreq = wr; p1_addr = addr; p1_in = data; p1_burstlen = len;
            if (push && rd) for (int i = 0; i < n; i++) q1.push_back(rom((addr >> 2) + 32'(i)));
        end
    endtask

    task automatic clr_reqs();
        p0_rdreq = 1'b0; p0_wrreq = 1'b0; p1_rdreq = 1'b0; p1_wrreq = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(p0_ready && p1_ready) && n < 200) begin
            cyc();
            n++;
        end
        check("idle_timeout", 64'(p0_ready && p1_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        p0_addr = '0; p0_in = '0; p0_burstlen = '0;
        p1_addr = '0; p1_in = '0; p1_burstlen = '0;
        clr_reqs();
        cyc(); cyc();
        // Reset state
        check("rst_p0_ready", 64'(p0_ready), 64'd1);
        check("rst_p1_ready", 64'(p1_ready), 64'd1);
        check("rst_mem_rdreq", 64'(mem_rdreq), 64'd0);
        check("rst_mem_wrreq", 64'(mem_wrreq), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_p0_out_valid", 64'(p0_out_valid), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Single-word read on port 0
        set_req(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 16'd1, 1'b1);
        cyc(); clr_reqs();
        check("r1_mem_rdreq", 64'(mem_rdreq), 64'd1);
        check("r1_mem_addr", 64'(mem_addr), 64'h80);
        check("r1_mem_burstlen", 64'(mem_burstlen), 64'd1);
        check("r1_p0_ready_low", 64'(p0_ready), 64'd0);
        cyc();
        check("r1_mem_rdreq_pulse", 64'(mem_rdreq), 64'd0);
        check("r1_p0_out_valid", 64'(p0_out_valid), 64'd1);
        check("r1_p0_out", 64'(p0_out), 64'hC0DE0020);
        cyc();
        check("r1_p0_ready_back", 64'(p0_ready), 64'd1);

        // Simultaneous reads after reset: port 0 first, port 1 after
        reset_n = 1'b0; cyc(); reset_n = 1'b1; cyc();
        set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 16'd2, 1'b1);
        set_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 16'd2, 1'b1);
        cyc(); clr_reqs();
        check("tie_first_rdreq", 64'(mem_rdreq), 64'd1);
        check("tie_first_addr", 64'(mem_addr), 64'h100);
        check("tie_p1_ready_low", 64'(p1_ready), 64'd0);
        cyc(); cyc(); cyc();
        check("tie_gap_rdreq", 64'(mem_rdreq), 64'd0);
        check("tie_p0_ready", 64'(p0_ready), 64'd1);
        cyc();
        check("tie_second_rdreq", 64'(mem_rdreq), 64'd1);
        check("tie_second_addr", 64'(mem_addr), 64'h200);
        wait_idle();

        // Port 1 burst of 4, port 0 request arrives mid-burst
        set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 16'd4, 1'b1);
        cyc(); clr_reqs();
        check("b4_rdreq", 64'(mem_rdreq), 64'd1);
        check("b4_burstlen", 64'(mem_burstlen), 64'd4);
        cyc();
        set_req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 16'd1, 1'b1);
        cyc(); clr_reqs();
        check("b4_p0_ready_low", 64'(p0_ready), 64'd0);
        check("b4_no_rdreq", 64'(mem_rdreq), 64'd0);
        cyc(); cyc(); cyc();
        check("b4_p1_ready", 64'(p1_ready), 64'd1);
        check("b4_idle_rdreq", 64'(mem_rdreq), 64'd0);
        check("b4_p0_still_wait", 64'(p0_ready), 64'd0);
        cyc();
        check("b4_p0_rdreq", 64'(mem_rdreq), 64'd1);
        check("b4_p0_addr", 64'(mem_addr), 64'h400);
        wait_idle();

        // Port 1 single write
        set_req(1'b1, 1'b0, 1'b1, 32'h88, 32'hDEADBEEF, 16'd0, 1'b0);
        cyc(); clr_reqs();
        check("wr_wrreq", 64'(mem_wrreq), 64'd1);
        check("wr_rdreq", 64'(mem_rdreq), 64'd0);
        check("wr_mem_in", 64'(mem_in), 64'hDEADBEEF);
        check("wr_mem_addr", 64'(mem_addr), 64'h88);
        check("wr_p1_ready_low", 64'(p1_ready), 64'd0);
        cyc();
        check("wr_wrreq_pulse", 64'(mem_wrreq), 64'd0);
        check("wr_p1_ready_back", 64'(p1_ready), 64'd1);

        // Read and write strobes together: treated as a read
        set_req(1'b0, 1'b1, 1'b1, 32'h90, 32'h1234, 16'd1, 1'b1);
        cyc(); clr_reqs();
        check("rw_rdreq", 64'(mem_rdreq), 64'd1);
        check("rw_wrreq", 64'(mem_wrreq), 64'd0);
        check("rw_addr", 64'(mem_addr), 64'h90);
        wait_idle();

        // Burst length 0 returns one word; request while busy is ignored
        set_req(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 16'd0, 1'b1);
        cyc(); clr_reqs();
        check("z_rdreq", 64'(mem_rdreq), 64'd1);
        check("z_burstlen", 64'(mem_burstlen), 64'd0);
        set_req(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 16'd1, 1'b0);
        cyc(); clr_reqs();
        check("z_valid", 64'(p0_out_valid), 64'd1);
        cyc();
        check("z_p0_ready", 64'(p0_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("z_ignored_rdreq", 64'(mem_rdreq), 64'd0);
            cyc();
        end

        // Tie after port 0 was last granted: port 1 wins
        set_req(1'b0, 1'b1, 1'b0, 32'hA0, 32'h0, 16'd1, 1'b1);
        set_req(1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 16'd1, 1'b1);
        cyc(); clr_reqs();
        check("rr_addr", 64'(mem_addr), 64'hB0);
        wait_idle();

        // Reset in the middle of a burst
        set_req(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 16'd4, 1'b1);
        cyc(); clr_reqs();
        cyc();
        #2 reset_n = 1'b0;
        #1;
        check("mr_p0_out_valid", 64'(p0_out_valid), 64'd0);
        check("mr_p0_out", 64'(p0_out), 64'd0);
        check("mr_mem_rdreq", 64'(mem_rdreq), 64'd0);
        check("mr_mem_addr", 64'(mem_addr), 64'd0);
        check("mr_mem_burstlen", 64'(mem_burstlen), 64'd0);
        check("mr_p0_ready", 64'(p0_ready), 64'd1);
        q0.delete();
        cyc();
        reset_n = 1'b1;
        check("mr_late_mem_valid", 64'(mem_out_valid), 64'd1);
        check("mr_late_p0_valid", 64'(p0_out_valid), 64'd0);
        cyc(); cyc(); cyc(); cyc();
        check("mr_no_rdreq", 64'(mem_rdreq), 64'd0);
        check("end_q0_empty", 64'(q0.size()), 64'd0);
        check("end_q1_empty", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
